// File: rtl/reorder_buf_pkg.sv
// Shared reorder-buffer definitions: entry kind encodings and datapath widths.
package reorder_buf_pkg;

  localparam int DATA_W = 32;
  localparam int DEST_W = 5;

  typedef enum logic [1:0] {
    KIND_REG    = 2'd0,
    KIND_STORE  = 2'd1,
    KIND_BRANCH = 2'd2,
    KIND_JALR   = 2'd3
  } rob_kind_e;

  function automatic logic is_ctrl(rob_kind_e k);
    return (k == KIND_BRANCH) || (k == KIND_JALR);
  endfunction

endpackage

// File: rtl/reorder_buf_commit_sel.sv
// Retire-select for the reorder buffer: qualifies the head slot, the optional
// second slot, store hand-off and redirect detection from the head entries.
module rob_commit_sel
  import reorder_buf_pkg::*;
#(
  parameter int COMMIT_W = 2
) (
  input  logic       head_valid,
  input  logic [1:0] head_kind,
  input  logic       head_ready,
  input  logic       head_issued,
  input  logic       head_redir,
  input  logic       next_valid,
  input  logic [1:0] next_kind,
  input  logic       next_ready,
  input  logic       str_done,
  output logic       pop0,
  output logic       pop1,
  output logic       write0,
  output logic       store_issue,
  output logic       redirect
);

  rob_kind_e k0, k1;

  assign k0 = rob_kind_e'(head_kind);
  assign k1 = rob_kind_e'(next_kind);

  // A store only leaves the head once memory has acknowledged the issued write.
  assign store_issue = head_valid && (k0 == KIND_STORE) && head_ready && !head_issued;
  assign redirect    = head_valid && head_ready && is_ctrl(k0) && head_redir;
  assign pop0        = head_valid &&
                       ((head_ready && (k0 != KIND_STORE)) ||
                        ((k0 == KIND_STORE) && head_issued && str_done));
  assign write0      = pop0 && ((k0 == KIND_REG) || (k0 == KIND_JALR));

  generate
    if (COMMIT_W > 1) begin : g_dual
      assign pop1 = pop0 && (k0 == KIND_REG) && next_valid && (k1 == KIND_REG) && next_ready;
    end else begin : g_single
      assign pop1 = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/reorder_buf.sv
// Reorder buffer: in-order allocate, out-of-order writeback, in-order retire.
// Define ROB_BYPASS_EN to forward same-cycle writebacks to the rs lookups.
module reorder_buf
  import reorder_buf_pkg::*;
#(
  parameter  int DEPTH    = 16,
  parameter  int WB_PORTS = 2,
  parameter  int COMMIT_W = 2,
  localparam int TAG_W    = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         alloc_valid,
  input  logic [4:0]                   alloc_dest,
  input  logic [1:0]                   alloc_kind,
  output logic                         alloc_ready,
  output logic [TAG_W-1:0]             alloc_tag,
  input  logic [WB_PORTS-1:0]          wb_valid,
  input  logic [WB_PORTS*TAG_W-1:0]    wb_tag,
  input  logic [WB_PORTS*32-1:0]       wb_value,
  input  logic [WB_PORTS-1:0]          wb_redir,
  input  logic [WB_PORTS*32-1:0]       wb_pc,
  input  logic [TAG_W-1:0]             rs1_tag,
  input  logic [TAG_W-1:0]             rs2_tag,
  output logic                         rs1_ready,
  output logic                         rs2_ready,
  output logic [31:0]                  rs1_value,
  output logic [31:0]                  rs2_value,
  output logic [COMMIT_W-1:0]          cmt_valid,
  output logic [COMMIT_W*5-1:0]        cmt_dest,
  output logic [COMMIT_W*32-1:0]       cmt_value,
  output logic                         str_commit,
  input  logic                         str_done,
  output logic                         flush,
  output logic [31:0]                  flush_pc,
  output logic [TAG_W-1:0]             head_tag,
  output logic [TAG_W:0]               count
);

  logic [TAG_W:0]      head, tail;
  logic [TAG_W-1:0]    head_idx, next_idx, tail_idx;
  logic [DEPTH-1:0]    ready_q, issued_q, redir_q;
  logic [1:0]          kind_q  [DEPTH];
  logic [DEST_W-1:0]   dest_q  [DEPTH];
  logic [DATA_W-1:0]   value_q [DEPTH];
  logic [DATA_W-1:0]   pc_q    [DEPTH];
  logic                full, empty, alloc_fire;
  logic                pop0, pop1, write0, store_issue, redirect;

  logic [COMMIT_W-1:0]        cmt_valid_d;
  logic [COMMIT_W*5-1:0]      cmt_dest_d;
  logic [COMMIT_W*DATA_W-1:0] cmt_value_d;

  assign head_idx = head[TAG_W-1:0];
  assign tail_idx = tail[TAG_W-1:0];
  assign next_idx = head_idx + TAG_W'(1);

  // The extra wrap bit tells full from empty when the indices coincide.
  assign empty = (head == tail);
  assign full  = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);

  assign count       = tail - head;
  assign head_tag    = head_idx;
  assign alloc_tag   = tail_idx;
  assign alloc_ready = !full && !flush;
  assign alloc_fire  = alloc_valid && alloc_ready;

  rob_commit_sel #(
    .COMMIT_W (COMMIT_W)
  ) u_sel (
    .head_valid  (!empty),
    .head_kind   (kind_q[head_idx]),
    .head_ready  (ready_q[head_idx]),
    .head_issued (issued_q[head_idx]),
    .head_redir  (redir_q[head_idx]),
    .next_valid  (count > (TAG_W+1)'(1)),
    .next_kind   (kind_q[next_idx]),
    .next_ready  (ready_q[next_idx]),
    .str_done    (str_done),
    .pop0        (pop0),
    .pop1        (pop1),
    .write0      (write0),
    .store_issue (store_issue),
    .redirect    (redirect)
  );

  assign cmt_valid_d[0]          = write0;
  assign cmt_dest_d[4:0]         = dest_q[head_idx];
  assign cmt_value_d[DATA_W-1:0] = value_q[head_idx];

  generate
    if (COMMIT_W > 1) begin : g_slot1
      assign cmt_valid_d[1]                 = pop1;
      assign cmt_dest_d[9:5]                = dest_q[next_idx];
      assign cmt_value_d[2*DATA_W-1:DATA_W] = value_q[next_idx];
    end
  endgenerate

  always_comb begin
    rs1_ready = ready_q[rs1_tag];
    rs1_value = value_q[rs1_tag];
    rs2_ready = ready_q[rs2_tag];
    rs2_value = value_q[rs2_tag];
`ifdef ROB_BYPASS_EN
    for (int i = 0; i < WB_PORTS; i++) begin
      if (wb_valid[i] && (wb_tag[i*TAG_W +: TAG_W] == rs1_tag)) begin
        rs1_ready = 1'b1;
        rs1_value = wb_value[i*DATA_W +: DATA_W];
      end
      if (wb_valid[i] && (wb_tag[i*TAG_W +: TAG_W] == rs2_tag)) begin
        rs2_ready = 1'b1;
        rs2_value = wb_value[i*DATA_W +: DATA_W];
      end
    end
`endif
  end

  // The flush cycle wipes the buffer and swallows any alloc or writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      ready_q    <= '0;
      issued_q   <= '0;
      redir_q    <= '0;
      cmt_valid  <= '0;
      cmt_dest   <= '0;
      cmt_value  <= '0;
      str_commit <= 1'b0;
      flush      <= 1'b0;
      flush_pc   <= '0;
    end else if (rdy) begin
      if (flush) begin
        head       <= '0;
        tail       <= '0;
        ready_q    <= '0;
        issued_q   <= '0;
        redir_q    <= '0;
        cmt_valid  <= '0;
        str_commit <= 1'b0;
        flush      <= 1'b0;
      end else begin
        cmt_valid  <= cmt_valid_d;
        cmt_dest   <= cmt_dest_d;
        cmt_value  <= cmt_value_d;
        str_commit <= store_issue;
        flush      <= redirect;
        if (redirect) begin
          flush_pc <= pc_q[head_idx];
        end
        head <= head + (TAG_W+1)'(pop0) + (TAG_W+1)'(pop1);
        if (store_issue) begin
          issued_q[head_idx] <= 1'b1;
        end
        if (alloc_fire) begin
          tail               <= tail + (TAG_W+1)'(1);
          ready_q[tail_idx]  <= 1'b0;
          issued_q[tail_idx] <= 1'b0;
          redir_q[tail_idx]  <= 1'b0;
          kind_q[tail_idx]   <= alloc_kind;
          dest_q[tail_idx]   <= alloc_dest;
        end
        // Later ports overwrite earlier ones when they target the same tag.
        for (int i = 0; i < WB_PORTS; i++) begin
          if (wb_valid[i]) begin
            ready_q[wb_tag[i*TAG_W +: TAG_W]] <= 1'b1;
            redir_q[wb_tag[i*TAG_W +: TAG_W]] <= wb_redir[i];
            value_q[wb_tag[i*TAG_W +: TAG_W]] <= wb_value[i*DATA_W +: DATA_W];
            pc_q[wb_tag[i*TAG_W +: TAG_W]]    <= wb_pc[i*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_reorder_buf.sv
// Directed bench for reorder_buf: table-driven retire vectors plus hand-written
// sequences for fill/full, wrap, flush, store hand-off and reset.
module tb_reorder_buf;

  localparam int DEPTH    = 16;
  localparam int WB_PORTS = 2;
  localparam int COMMIT_W = 2;
  localparam int TAG_W    = 4;

  localparam logic [1:0] K_REG    = 2'd0;
  localparam logic [1:0] K_STORE  = 2'd1;
  localparam logic [1:0] K_BRANCH = 2'd2;
  localparam logic [1:0] K_JALR   = 2'd3;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        alloc_valid, alloc_ready;
  logic [4:0]  alloc_dest;
  logic [1:0]  alloc_kind;
  logic [3:0]  alloc_tag;
  logic [1:0]  wb_valid, wb_redir;
  logic [7:0]  wb_tag;
  logic [63:0] wb_value, wb_pc;
  logic [3:0]  rs1_tag, rs2_tag;
  logic        rs1_ready, rs2_ready;
  logic [31:0] rs1_value, rs2_value;
  logic [1:0]  cmt_valid;
  logic [9:0]  cmt_dest;
  logic [63:0] cmt_value;
  logic        str_commit, str_done, flush;
  logic [31:0] flush_pc;
  logic [3:0]  head_tag;
  logic [4:0]  count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rdy;
    logic        a_valid;
    logic [1:0]  w_valid;
    logic [3:0]  t0, t1;
    logic [31:0] v0, v1;
    logic [1:0]  e_cmt;
    logic [31:0] e_v0, e_v1;
    logic [4:0]  e_count;
    logic [3:0]  e_head;
  } vec_t;

  vec_t tbl [12];

  reorder_buf #(
    .DEPTH    (DEPTH),
    .WB_PORTS (WB_PORTS),
    .COMMIT_W (COMMIT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .alloc_valid (alloc_valid),
    .alloc_dest  (alloc_dest),
    .alloc_kind  (alloc_kind),
    .alloc_ready (alloc_ready),
    .alloc_tag   (alloc_tag),
    .wb_valid    (wb_valid),
    .wb_tag      (wb_tag),
    .wb_value    (wb_value),
    .wb_redir    (wb_redir),
    .wb_pc       (wb_pc),
    .rs1_tag     (rs1_tag),
    .rs2_tag     (rs2_tag),
    .rs1_ready   (rs1_ready),
    .rs2_ready   (rs2_ready),
    .rs1_value   (rs1_value),
    .rs2_value   (rs2_value),
    .cmt_valid   (cmt_valid),
    .cmt_dest    (cmt_dest),
    .cmt_value   (cmt_value),
    .str_commit  (str_commit),
    .str_done    (str_done),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .head_tag    (head_tag),
    .count       (count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic r, input logic av, input logic [1:0] wv,
                              input logic [3:0] t0, input logic [31:0] v0,
                              input logic [3:0] t1, input logic [31:0] v1,
                              input logic [1:0] ec, input logic [31:0] ev0,
                              input logic [31:0] ev1, input logic [4:0] ecnt,
                              input logic [3:0] ehead);
    vec_t v;
    v.rdy = r;   v.a_valid = av; v.w_valid = wv;
    v.t0 = t0;   v.v0 = v0;      v.t1 = t1;   v.v1 = v1;
    v.e_cmt = ec; v.e_v0 = ev0;  v.e_v1 = ev1;
    v.e_count = ecnt; v.e_head = ehead;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rdy         = 1'b1;
    alloc_valid = 1'b0;
    alloc_kind  = K_REG;
    alloc_dest  = 5'd0;
    wb_valid    = '0;
    wb_tag      = '0;
    wb_value    = '0;
    wb_redir    = '0;
    wb_pc       = '0;
    str_done    = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wb_set(input int p, input logic [3:0] tag, input logic [31:0] val,
                        input logic redir, input logic [31:0] pc);
    wb_valid[p]         = 1'b1;
    wb_tag[p*4 +: 4]    = tag;
    wb_value[p*32 +: 32] = val;
    wb_redir[p]         = redir;
    wb_pc[p*32 +: 32]   = pc;
  endtask

  task automatic alloc(input logic [1:0] kind, input logic [4:0] dest);
    clear_inputs();
    alloc_valid = 1'b1;
    alloc_kind  = kind;
    alloc_dest  = dest;
    step();
    clear_inputs();
  endtask

  task automatic apply_stimulus(input vec_t v);
    clear_inputs();
    rdy         = v.rdy;
    alloc_valid = v.a_valid;
    alloc_dest  = 5'd9;
    if (v.w_valid[0]) wb_set(0, v.t0, v.v0, 1'b0, 32'h0);
    if (v.w_valid[1]) wb_set(1, v.t1, v.v1, 1'b0, 32'h0);
    step();
    clear_inputs();
  endtask

  initial begin
    rs1_tag = '0;
    rs2_tag = '0;
    rst     = 1'b1;
    clear_inputs();

    // Reset state
    do_reset();
    check_output("rst_count", count, 0);
    check_output("rst_alloc_ready", alloc_ready, 1);
    check_output("rst_alloc_tag", alloc_tag, 0);
    check_output("rst_head_tag", head_tag, 0);
    check_output("rst_cmt_valid", cmt_valid, 0);
    check_output("rst_flush", flush, 0);
    check_output("rst_flush_pc", flush_pc, 0);
    check_output("rst_str_commit", str_commit, 0);

    // Fill to full, then commit the head while a blocked alloc is offered
    for (int i = 0; i < 16; i++) alloc(K_REG, 5'(i + 1));
    check_output("full_count", count, 16);
    check_output("full_alloc_ready", alloc_ready, 0);
    alloc(K_REG, 5'd20);
    check_output("full_alloc_blocked_count", count, 16);
    wb_set(0, 4'd0, 32'h11, 1'b0, 32'h0);
    step();
    clear_inputs();
    check_output("wb0_no_commit_yet", cmt_valid, 0);
    alloc_valid = 1'b1;
    step();
    clear_inputs();
    check_output("first_cmt_valid", cmt_valid, 2'b01);
    check_output("first_cmt_value", cmt_value[31:0], 32'h11);
    check_output("first_cmt_dest", cmt_dest[4:0], 5'd1);
    check_output("precommit_full_count", count, 15);
    check_output("after_commit_alloc_ready", alloc_ready, 1);

    // Table: dual retire, port priority, rdy hold
    tbl[0]  = mk(1, 0, 2'b11, 1, 32'h21, 2, 32'h22, 2'b00, 0, 0, 15, 1);
    tbl[1]  = mk(1, 0, 2'b00, 0, 0, 0, 0, 2'b11, 32'h21, 32'h22, 13, 3);
    tbl[2]  = mk(1, 0, 2'b11, 3, 32'h33, 4, 32'h44, 2'b00, 0, 0, 13, 3);
    tbl[3]  = mk(1, 0, 2'b00, 0, 0, 0, 0, 2'b11, 32'h33, 32'h44, 11, 5);
    tbl[4]  = mk(1, 0, 2'b11, 5, 32'hAA, 5, 32'h55, 2'b00, 0, 0, 11, 5);
    tbl[5]  = mk(1, 0, 2'b00, 0, 0, 0, 0, 2'b01, 32'h55, 0, 10, 6);
    tbl[6]  = mk(1, 0, 2'b01, 7, 32'h77, 0, 0, 2'b00, 0, 0, 10, 6);
    tbl[7]  = mk(1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 10, 6);
    tbl[8]  = mk(1, 1, 2'b01, 6, 32'h66, 0, 0, 2'b00, 0, 0, 11, 6);
    tbl[9]  = mk(1, 0, 2'b00, 0, 0, 0, 0, 2'b11, 32'h66, 32'h77, 9, 8);
    tbl[10] = mk(0, 1, 2'b01, 8, 32'h88, 0, 0, 2'b11, 32'h66, 32'h77, 9, 8);
    tbl[11] = mk(1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 9, 8);
    for (int r = 0; r < 12; r++) begin
      apply_stimulus(tbl[r]);
      check_output($sformatf("row%0d_cmt_valid", r), cmt_valid, tbl[r].e_cmt);
      check_output($sformatf("row%0d_count", r), count, tbl[r].e_count);
      check_output($sformatf("row%0d_head", r), head_tag, tbl[r].e_head);
      if (tbl[r].e_cmt[0]) check_output($sformatf("row%0d_v0", r), cmt_value[31:0], tbl[r].e_v0);
      if (tbl[r].e_cmt[1]) check_output($sformatf("row%0d_v1", r), cmt_value[63:32], tbl[r].e_v1);
    end

    // Wrap: walk head to index 15, then fill and retire across the boundary
    do_reset();
    for (int i = 0; i < 15; i++) alloc(K_REG, 5'd1);
    for (int i = 0; i < 15; i++) begin
      wb_set(0, 4'(i), 32'(i), 1'b0, 32'h0);
      step();
      clear_inputs();
    end
    step();
    step();
    check_output("wrap_empty_count", count, 0);
    check_output("wrap_head15", head_tag, 15);
    check_output("wrap_empty_alloc_ready", alloc_ready, 1);
    for (int i = 0; i < 16; i++) alloc(K_REG, 5'd2);
    check_output("wrap_full_count", count, 16);
    check_output("wrap_full_alloc_ready", alloc_ready, 0);
    wb_set(0, 4'd15, 32'h15F, 1'b0, 32'h0);
    step();
    clear_inputs();
    step();
    check_output("wrap_cmt_value", cmt_value[31:0], 32'h15F);
    check_output("wrap_head0", head_tag, 0);
    check_output("wrap_count15", count, 15);
    check_output("wrap_alloc_ready", alloc_ready, 1);
    step();
    check_output("wrap_stale_ready_cleared", cmt_valid, 0);

    // Branch redirect flush
    do_reset();
    for (int i = 0; i < 5; i++) alloc(K_REG, 5'(i + 1));
    alloc(K_BRANCH, 5'd0);
    alloc(K_REG, 5'd7);
    rs1_tag = 4'd0;
    rs2_tag = 4'd1;
    wb_set(0, 4'd0, 32'h10, 1'b0, 32'h0);
    wb_set(1, 4'd1, 32'h11, 1'b0, 32'h0);
    #1;
`ifdef ROB_BYPASS_EN
    check_output("bypass_rs1_ready", rs1_ready, 1);
    check_output("bypass_rs1_value", rs1_value, 32'h10);
`else
    check_output("nobypass_rs1_ready", rs1_ready, 0);
`endif
    step();
    clear_inputs();
    check_output("rs1_ready_next", rs1_ready, 1);
    check_output("rs2_value_next", rs2_value, 32'h11);
    wb_set(0, 4'd2, 32'h12, 1'b0, 32'h0);
    wb_set(1, 4'd3, 32'h13, 1'b0, 32'h0);
    step();
    clear_inputs();
    wb_set(0, 4'd4, 32'h14, 1'b0, 32'h0);
    wb_set(1, 4'd5, 32'h0, 1'b1, 32'h100);
    step();
    clear_inputs();
    step();
    check_output("br_pre_cmt_valid", cmt_valid, 2'b01);
    check_output("br_pre_flush", flush, 0);
    step();
    check_output("br_flush", flush, 1);
    check_output("br_flush_pc", flush_pc, 32'h100);
    check_output("br_flush_cmt_valid", cmt_valid, 0);
    check_output("br_flush_alloc_ready", alloc_ready, 0);
    alloc_valid = 1'b1;
    rs1_tag = 4'd6;
    wb_set(0, 4'd6, 32'h66, 1'b0, 32'h0);
    step();
    clear_inputs();
    check_output("br_after_flush", flush, 0);
    check_output("br_after_count", count, 0);
    check_output("br_after_alloc_tag", alloc_tag, 0);
    check_output("br_after_wb_ignored", rs1_ready, 0);

    // JALR with redirect commits its link value and flushes
    alloc(K_JALR, 5'd7);
    wb_set(0, 4'd0, 32'h99, 1'b1, 32'h200);
    step();
    clear_inputs();
    step();
    check_output("jalr_cmt_valid", cmt_valid, 2'b01);
    check_output("jalr_cmt_value", cmt_value[31:0], 32'h99);
    check_output("jalr_cmt_dest", cmt_dest[4:0], 5'd7);
    check_output("jalr_flush", flush, 1);
    check_output("jalr_flush_pc", flush_pc, 32'h200);
    step();
    check_output("jalr_after_count", count, 0);

    // Branch without redirect retires silently
    alloc(K_BRANCH, 5'd3);
    wb_set(0, 4'd0, 32'h0, 1'b0, 32'h300);
    step();
    clear_inputs();
    step();
    check_output("br_nr_cmt_valid", cmt_valid, 0);
    check_output("br_nr_flush", flush, 0);
    check_output("br_nr_head", head_tag, 1);

    // Store hand-off
    do_reset();
    alloc(K_STORE, 5'd0);
    alloc(K_REG, 5'd3);
    str_done = 1'b1;
    step();
    clear_inputs();
    check_output("st_spurious_done_count", count, 2);
    wb_set(0, 4'd0, 32'h0, 1'b0, 32'h0);
    wb_set(1, 4'd1, 32'h31, 1'b0, 32'h0);
    step();
    clear_inputs();
    check_output("st_no_pulse_yet", str_commit, 0);
    step();
    check_output("st_pulse", str_commit, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_output($sformatf("st_wait%0d_pulse", i), str_commit, 0);
      check_output($sformatf("st_wait%0d_count", i), count, 2);
    end
    str_done = 1'b1;
    step();
    clear_inputs();
    check_output("st_pop_count", count, 1);
    check_output("st_pop_head", head_tag, 1);
    check_output("st_pop_cmt_valid", cmt_valid, 0);
    step();
    check_output("st_next_cmt_valid", cmt_valid, 2'b01);
    check_output("st_next_cmt_value", cmt_value[31:0], 32'h31);

    // Reset while a store is in flight discards it
    do_reset();
    alloc(K_STORE, 5'd0);
    wb_set(0, 4'd0, 32'h0, 1'b0, 32'h0);
    step();
    clear_inputs();
    step();
    check_output("rst_st_pulse", str_commit, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_output("rst_st_count", count, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_output($sformatf("rst_st_no_reissue%0d", i), str_commit, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
